// File: rtl/spu_carry_chain_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spu_carry_chain_pipe_pkg
// Purpose  : Shared types and helpers for the SPU carry-chain primitive.
//            chain_bit() evaluates one cell of the mux-style carry chain:
//            sum   = propagate XOR carry-in
//            carry = propagate ? carry-in : generate-data
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package spu_carry_chain_pipe_pkg;

  typedef struct packed {
    logic sum;
    logic carry;
  } chain_bit_t;

  function automatic chain_bit_t chain_bit(input logic sel, input logic gen, input logic cin);
    chain_bit_t r;
    r.sum   = sel ^ cin;
    r.carry = sel ? cin : gen;
    return r;
  endfunction

endpackage : spu_carry_chain_pipe_pkg
`default_nettype wire

// File: rtl/spu_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : spu_delay_line
// Purpose  : LATENCY-deep register delay line with clock enable, optional
//            synchronous clear and optional input qualifier on the first
//            stage. LATENCY = 0 gives a combinational path that still honours
//            clear.
// Ports    : clk    - clock, rising edge
//            reset  - asynchronous active-high reset, loads CLEAR_VALUE
//            cke    - clock enable, all stages hold when low
//            clear  - synchronous clear request (used when USE_CLEAR != 0)
//            valid  - first-stage load qualifier (used when USE_VALID != 0)
//            din    - data into the line
//            dout   - data out of the line
// Revision : 1.0  initial release
// ============================================================================
module spu_delay_line #(
  parameter int               LATENCY     = 1,
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
  parameter int               USE_CLEAR   = 0,
  parameter int               USE_VALID   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cke,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Depending on the parameter set some control inputs have no effect;
  // fold them together so they remain visibly consumed.
  logic w_unused_inputs;
  assign w_unused_inputs = ^{clk, reset, cke, clear, valid};

  generate
    if (LATENCY == 0) begin : g_comb
      // Valid has no meaning without a register to hold; only clear acts here.
      assign dout = ((USE_CLEAR != 0) && clear) ? CLEAR_VALUE : din;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [LATENCY];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LATENCY; i++) begin
            r_stage[i] <= CLEAR_VALUE;
          end
        end else if (cke) begin
          // Only the first stage is qualified; clear wins over valid.
          if ((USE_CLEAR != 0) && clear) begin
            r_stage[0] <= CLEAR_VALUE;
          end else if ((USE_VALID == 0) || valid) begin
            r_stage[0] <= din;
          end
          // Later stages shift unconditionally while enabled.
          for (int i = 1; i < LATENCY; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign dout = r_stage[LATENCY-1];
    end
  endgenerate

endmodule : spu_delay_line
`default_nettype wire

// File: rtl/spu_carry_chain_pipe.sv
`default_nettype none
// ============================================================================
// Module   : spu_carry_chain_pipe
// Purpose  : Generic carry-chain arithmetic primitive followed by a
//            LATENCY-cycle delay on both the sum and the per-bit carry-out.
//            The caller supplies per-bit propagate (s_sin) and generate
//            data (s_din); e.g. add uses sin = a^b, din = a, cin = 0 and
//            subtract uses sin = a^~b, din = a, cin = 1.
// Ports    : clk      - clock, rising edge
//            reset    - asynchronous active-high reset
//            cke      - clock enable
//            s_cin    - carry into bit 0
//            s_sin    - per-bit propagate select   [DATA_BITS]
//            s_din    - per-bit generate data      [DATA_BITS]
//            s_clear  - synchronous clear request
//            s_valid  - input qualifier
//            m_dout   - delayed sum bits           [DATA_BITS]
//            m_cout   - delayed carry-out per bit  [DATA_BITS]
// Revision : 1.0  initial release
// ============================================================================
module spu_carry_chain_pipe
  import spu_carry_chain_pipe_pkg::*;
#(
  parameter int                   LATENCY    = 1,
  parameter int                   DATA_BITS  = 8,
  parameter logic [DATA_BITS-1:0] CLEAR_DATA = '0,
  parameter logic [DATA_BITS-1:0] CLEAR_COUT = '0,
  parameter int                   USE_CLEAR  = 0,
  parameter int                   USE_VALID  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic                 s_cin,
  input  logic [DATA_BITS-1:0] s_sin,
  input  logic [DATA_BITS-1:0] s_din,
  input  logic                 s_clear,
  input  logic                 s_valid,
  output logic [DATA_BITS-1:0] m_dout,
  output logic [DATA_BITS-1:0] m_cout
);

  logic [DATA_BITS-1:0] w_dout;
  logic [DATA_BITS-1:0] w_cout;

  // Ripple through the chain with a block-local carry so the carry-out
  // vector is only ever written here, never read back into itself.
  always_comb begin
    logic       v_carry;
    chain_bit_t v_bit;
    w_dout  = '0;
    w_cout  = '0;
    v_carry = s_cin;
    v_bit   = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      v_bit     = chain_bit(s_sin[i], s_din[i], v_carry);
      w_dout[i] = v_bit.sum;
      w_cout[i] = v_bit.carry;
      v_carry   = v_bit.carry;
    end
  end

  spu_delay_line #(
    .LATENCY     (LATENCY),
    .WIDTH       (DATA_BITS),
    .CLEAR_VALUE (CLEAR_DATA),
    .USE_CLEAR   (USE_CLEAR),
    .USE_VALID   (USE_VALID)
  ) u_dout_line (
    .clk   (clk),
    .reset (reset),
    .cke   (cke),
    .clear (s_clear),
    .valid (s_valid),
    .din   (w_dout),
    .dout  (m_dout)
  );

  spu_delay_line #(
    .LATENCY     (LATENCY),
    .WIDTH       (DATA_BITS),
    .CLEAR_VALUE (CLEAR_COUT),
    .USE_CLEAR   (USE_CLEAR),
    .USE_VALID   (USE_VALID)
  ) u_cout_line (
    .clk   (clk),
    .reset (reset),
    .cke   (cke),
    .clear (s_clear),
    .valid (s_valid),
    .din   (w_cout),
    .dout  (m_cout)
  );

endmodule : spu_carry_chain_pipe
`default_nettype wire

// File: tb/tb_spu_carry_chain_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_spu_carry_chain_pipe
// Purpose  : Self-checking bench for spu_carry_chain_pipe. Three instances
//            share one input stream: LATENCY 1 (plain), LATENCY 0 (clear),
//            LATENCY 3 (clear + valid). Expected values come from an
//            arithmetic model: (sin, din) is mapped back to operands
//            a = din, b = din ^ sin, and sums/carries are taken from a+b+cin.
// Revision : 1.0  initial release
// ============================================================================
module tb_spu_carry_chain_pipe;

  localparam logic [7:0] CD0 = 8'h3C, CC0 = 8'hC3;
  localparam logic [7:0] CD3 = 8'hAA, CC3 = 8'h55;

  logic       clk = 1'b0;
  logic       reset, cke, s_cin, s_clear, s_valid;
  logic [7:0] s_sin, s_din;
  logic [7:0] u1_dout, u1_cout, u0_dout, u0_cout, u3_dout, u3_cout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m1;
  logic [15:0] m3_q[$];

  always #5 clk = ~clk;

  spu_carry_chain_pipe #(.LATENCY(1), .DATA_BITS(8)) u_l1 (
    .clk(clk), .reset(reset), .cke(cke), .s_cin(s_cin), .s_sin(s_sin), .s_din(s_din),
    .s_clear(s_clear), .s_valid(s_valid), .m_dout(u1_dout), .m_cout(u1_cout));

  spu_carry_chain_pipe #(.LATENCY(0), .DATA_BITS(8), .CLEAR_DATA(CD0), .CLEAR_COUT(CC0),
                         .USE_CLEAR(1), .USE_VALID(1)) u_l0 (
    .clk(clk), .reset(reset), .cke(cke), .s_cin(s_cin), .s_sin(s_sin), .s_din(s_din),
    .s_clear(s_clear), .s_valid(s_valid), .m_dout(u0_dout), .m_cout(u0_cout));

  spu_carry_chain_pipe #(.LATENCY(3), .DATA_BITS(8), .CLEAR_DATA(CD3), .CLEAR_COUT(CC3),
                         .USE_CLEAR(1), .USE_VALID(1)) u_l3 (
    .clk(clk), .reset(reset), .cke(cke), .s_cin(s_cin), .s_sin(s_sin), .s_din(s_din),
    .s_clear(s_clear), .s_valid(s_valid), .m_dout(u3_dout), .m_cout(u3_cout));

  // {sum[7:0], carry_out_of_bit[7:0]} from plain integer addition.
  function automatic logic [15:0] ref_chain(input logic cin, input logic [7:0] sin, input logic [7:0] din);
    int unsigned a, b, s, m;
    logic [7:0]  co;
    a = din;
    b = din ^ sin;
    for (int i = 0; i < 8; i++) begin
      m     = (32'd1 << (i + 1)) - 1;
      s     = (a & m) + (b & m) + cin;
      co[i] = s[i+1];
    end
    s = a + b + cin;
    return {s[7:0], co};
  endfunction

  function automatic logic [15:0] exp_l0();
    return s_clear ? {CD0, CC0} : ref_chain(s_cin, s_sin, s_din);
  endfunction

  task automatic model_reset();
    m1 = 16'h0000;
    m3_q.delete();
    for (int i = 0; i < 3; i++) m3_q.push_back({CD3, CC3});
  endtask

  task automatic apply(input logic cin, input logic [7:0] sin, input logic [7:0] din,
                       input logic clr, input logic vld, input logic ce);
    @(negedge clk);
    s_cin = cin; s_sin = sin; s_din = din; s_clear = clr; s_valid = vld; cke = ce;
    #1;
  endtask

  // Advance one clock and move the reference model along with it.
  task automatic tick();
    logic [15:0] r, nxt;
    @(posedge clk);
    if (cke) begin
      r   = ref_chain(s_cin, s_sin, s_din);
      m1  = r;
      nxt = s_clear ? {CD3, CC3} : (s_valid ? r : m3_q[$]);
      m3_q.push_back(nxt);
      void'(m3_q.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cke = 1'b0; s_cin = 1'b0; s_sin = '0; s_din = '0; s_clear = 1'b0; s_valid = 1'b0;
    #2;
    n_cmp++; if ({u1_dout, u1_cout} !== 16'h0000) begin n_bad++; $display("FAIL reset_l1: got %h expected %h", {u1_dout, u1_cout}, 16'h0000); end
    n_cmp++; if ({u3_dout, u3_cout} !== {CD3, CC3}) begin n_bad++; $display("FAIL reset_l3: got %h expected %h", {u3_dout, u3_cout}, {CD3, CC3}); end
    n_cmp++; if ({u0_dout, u0_cout} !== exp_l0()) begin n_bad++; $display("FAIL reset_l0: got %h expected %h", {u0_dout, u0_cout}, exp_l0()); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sub();
    apply(1'b1, 8'hF9, 8'h05, 1'b0, 1'b1, 1'b1);  // 0x05 - 0x03
    tick();
    n_cmp++; if (u1_dout !== 8'h02) begin n_bad++; $display("FAIL sub_dout: got %h expected %h", u1_dout, 8'h02); end
    n_cmp++; if (u1_cout[7] !== 1'b1) begin n_bad++; $display("FAIL sub_noborrow: got %b expected 1", u1_cout[7]); end
    n_cmp++; if ({u1_dout, u1_cout} !== m1) begin n_bad++; $display("FAIL sub_full: got %h expected %h", {u1_dout, u1_cout}, m1); end
    apply(1'b1, 8'hF9, 8'h03, 1'b0, 1'b1, 1'b1);  // 0x03 - 0x05
    tick();
    n_cmp++; if (u1_dout !== 8'hFE) begin n_bad++; $display("FAIL subb_dout: got %h expected %h", u1_dout, 8'hFE); end
    n_cmp++; if (u1_cout[7] !== 1'b0) begin n_bad++; $display("FAIL subb_borrow: got %b expected 0", u1_cout[7]); end
  endtask

  task automatic test_add_comb();
    apply(1'b0, 8'hFE, 8'hFF, 1'b0, 1'b1, 1'b1);  // 0xFF + 0x01, same cycle
    n_cmp++; if (u0_dout !== 8'h00) begin n_bad++; $display("FAIL add0_dout: got %h expected %h", u0_dout, 8'h00); end
    n_cmp++; if (u0_cout[7:6] !== 2'b11) begin n_bad++; $display("FAIL add0_cout76: got %b expected 11", u0_cout[7:6]); end
    n_cmp++; if (u0_cout !== 8'hFF) begin n_bad++; $display("FAIL add0_cout: got %h expected %h", u0_cout, 8'hFF); end
    tick();
  endtask

  task automatic test_overflow();
    apply(1'b0, 8'h7E, 8'h7F, 1'b0, 1'b1, 1'b1);  // 0x7F + 0x01
    n_cmp++; if (u0_dout !== 8'h80) begin n_bad++; $display("FAIL ovf_dout: got %h expected %h", u0_dout, 8'h80); end
    n_cmp++; if (u0_cout[7:6] !== 2'b01) begin n_bad++; $display("FAIL ovf_cout76: got %b expected 01", u0_cout[7:6]); end
    tick();
    n_cmp++; if ({u1_dout, u1_cout[7:6]} !== {8'h80, 2'b01}) begin n_bad++; $display("FAIL ovf_l1: got %h/%b expected 80/01", u1_dout, u1_cout[7:6]); end
  endtask

  task automatic test_valid_hold();
    logic [15:0] rx;
    apply(1'b0, 8'h5A, 8'h33, 1'b0, 1'b1, 1'b1);
    rx = ref_chain(1'b0, 8'h5A, 8'h33);
    tick();
    apply(1'b1, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b1);  // new data, not qualified
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if ({u3_dout, u3_cout} !== m3_q[0]) begin n_bad++; $display("FAIL vhold_model[%0d]: got %h expected %h", k, {u3_dout, u3_cout}, m3_q[0]); end
      if (k >= 2) begin
        n_cmp++; if ({u3_dout, u3_cout} !== rx) begin n_bad++; $display("FAIL vhold_value[%0d]: got %h expected %h", k, {u3_dout, u3_cout}, rx); end
      end
    end
  endtask

  task automatic test_clear();
    apply(1'b1, 8'h12, 8'h34, 1'b1, 1'b1, 1'b1);
    n_cmp++; if ({u0_dout, u0_cout} !== {CD0, CC0}) begin n_bad++; $display("FAIL clr_l0: got %h expected %h", {u0_dout, u0_cout}, {CD0, CC0}); end
    tick();
    apply(1'b0, 8'h99, 8'h66, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    n_cmp++; if ({u3_dout, u3_cout} !== {CD3, CC3}) begin n_bad++; $display("FAIL clr_l3: got %h expected %h", {u3_dout, u3_cout}, {CD3, CC3}); end
  endtask

  task automatic test_cke_hold();
    for (int k = 0; k < 3; k++) begin
      apply(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b1);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      apply(1'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b0);  // frozen, even clear
      tick();
      n_cmp++; if ({u1_dout, u1_cout} !== m1) begin n_bad++; $display("FAIL cke_l1[%0d]: got %h expected %h", k, {u1_dout, u1_cout}, m1); end
      n_cmp++; if ({u3_dout, u3_cout} !== m3_q[0]) begin n_bad++; $display("FAIL cke_l3[%0d]: got %h expected %h", k, {u3_dout, u3_cout}, m3_q[0]); end
    end
    for (int k = 0; k < 4; k++) begin
      apply(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b1);
      tick();
      n_cmp++; if ({u3_dout, u3_cout} !== m3_q[0]) begin n_bad++; $display("FAIL resume_l3[%0d]: got %h expected %h", k, {u3_dout, u3_cout}, m3_q[0]); end
    end
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 2; k++) begin
      apply(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b1);
      tick();
    end
    @(negedge clk);
    cke = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if ({u1_dout, u1_cout} !== 16'h0000) begin n_bad++; $display("FAIL midrst_l1: got %h expected %h", {u1_dout, u1_cout}, 16'h0000); end
    n_cmp++; if ({u3_dout, u3_cout} !== {CD3, CC3}) begin n_bad++; $display("FAIL midrst_l3: got %h expected %h", {u3_dout, u3_cout}, {CD3, CC3}); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) begin
      apply(1'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
            1'($urandom), ($urandom_range(0, 7) != 0));
      n_cmp++; if ({u0_dout, u0_cout} !== exp_l0()) begin n_bad++; $display("FAIL rnd_l0[%0d]: got %h expected %h", k, {u0_dout, u0_cout}, exp_l0()); end
      tick();
      n_cmp++; if ({u1_dout, u1_cout} !== m1) begin n_bad++; $display("FAIL rnd_l1[%0d]: got %h expected %h", k, {u1_dout, u1_cout}, m1); end
      n_cmp++; if ({u3_dout, u3_cout} !== m3_q[0]) begin n_bad++; $display("FAIL rnd_l3[%0d]: got %h expected %h", k, {u3_dout, u3_cout}, m3_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_add_comb();
    test_overflow();
    test_valid_hold();
    test_clear();
    test_cke_hold();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_spu_carry_chain_pipe
`default_nettype wire

// File: doc/spu_carry_chain_pipe.md
Name: spu_carry_chain_pipe

Overview:
- Generic carry-chain arithmetic primitive followed by a configurable pipeline delay with clear/valid control.
- Building block for SPU add/sub/compare ops.
- The caller pre-computes per-bit propagate (sin) and generate (din).
- The block produces the sum bits and the per-bit carry-out vector, delayed by LATENCY cycles.

Parameters:
- LATENCY, 1: pipeline depth in cycles; must be >= 0; 0 = purely combinational.
- DATA_BITS, 8: operand width; must be >= 1.
- CLEAR_DATA, 0: value loaded into the m_dout path on clear and on reset.
- CLEAR_COUT, 0: value loaded into the m_cout path on clear and on reset.
- USE_CLEAR, 0: 1 = s_clear honoured; 0 = s_clear ignored.
- USE_VALID, 0: 1 = s_valid gates updates; 0 = treated as always 1.

Ports:
- clk  in  1  clock; all registers on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cke  in  1  clock enable; registers hold when low.
- s_cin  in  1  carry into bit 0.
- s_sin  in  DATA_BITS  per-bit propagate select.
- s_din  in  DATA_BITS  per-bit generate data.
- s_clear  in  1  synchronous clear request.
- s_valid  in  1  input qualifier.
- m_dout  out  DATA_BITS  sum bits.
- m_cout  out  DATA_BITS  carry-out of every bit position.

Behaviour:
- Carry chain, combinational stage 0:
  - c[0] = s_cin.
  - dout[i] = s_sin[i] XOR c[i].
  - cout[i] = s_sin[i] ? c[i] : s_din[i].
  - c[i+1] = cout[i].
- Equivalent uses:
  - Add: sin = a^b, din = a, cin = 0 → {cout[N-1], dout} = a+b.
  - Subtract: sin = a^~b, din = a, cin = 1 → dout = a-b; cout[N-1] = 1 means no borrow.
  - cout[N-2] is the carry into the MSB, used for overflow detection.
- Pipeline: two parallel identical delay lines of LATENCY registers, one for dout and one for cout.
- Stage 1 register, when cke = 1:
  - if USE_CLEAR and s_clear: load CLEAR_DATA / CLEAR_COUT.
  - else if !USE_VALID or s_valid: load the combinational result.
  - else: hold.
- Stages 2..LATENCY shift unconditionally when cke = 1 and hold when cke = 0.
- cke = 0 freezes all stages, including clear; clear takes priority over valid.
- LATENCY = 0: outputs are combinational.
  - clear active (USE_CLEAR): outputs forced to the clear values.
  - otherwise: outputs equal the chain result.
  - valid has no effect at LATENCY 0.
- Reset: asynchronous; every stage register immediately becomes CLEAR_DATA / CLEAR_COUT, independent of cke.
- Reset mid-pipeline discards all in-flight data.
- First result after reset deassertion appears LATENCY cke-enabled cycles after capture.
- Throughput: one result per cke cycle; no backpressure.
- Width rule: no truncation. Final carry is cout[N-1]. For DATA_BITS = 1, cout[0] is the only carry.

Decomposition:
- Shared package: none required. CLEAR values are typed by the DATA_BITS-wide vector locally.
- Sub-module spu_delay_line: parameters LATENCY, WIDTH, CLEAR_VALUE, USE_CLEAR, USE_VALID. Instantiated twice, once for dout and once for cout.
- The carry chain is a generate loop in the top (vendor CARRY8 primitive optional).

Test Plan:
- Subtract, LATENCY=1, DATA_BITS=8: a=0x05, b=0x03, cin=1 → next cycle m_dout=0x02, m_cout[7]=1.
- Subtract with borrow, same setup: a=0x03, b=0x05 → m_dout=0xFE, m_cout[7]=0.
- Add, LATENCY=0: sin=0xFF^0x01, din=0xFF, cin=0 → same cycle m_dout=0x00, m_cout[7]=1, m_cout[6]=1.
- LATENCY=3, USE_VALID=1: pulse valid with one result, then valid=0 with new data → result emerges after 3 cycles, then repeats (stage 1 held).
- USE_CLEAR=1, CLEAR_DATA=0xAA: assert clear with data present → 0xAA appears at output LATENCY cycles later.
- Hold, reset and sign overflow:
  - cke=0 for 2 cycles mid-stream → outputs frozen, then resume in order.
  - reset asserted mid-stream → outputs immediately equal the clear values.
  - 0x7F+0x01 → m_cout[6]=1, m_cout[7]=0 (signed overflow).
